// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - decode/PC-side signal bundle for branch_ctrl
interface branch_ctrl_if #(
  parameter int AddrSz = 6
);
  logic [2:0]        op;
  logic [AddrSz-1:0] instr_off;
  logic              flag_we;
  logic              alu_zero;
  logic              alu_neg;
  logic              btn;
  logic              rel_branch;
  logic [AddrSz-1:0] offset;
  logic              halt;
  logic              in_strobe;
  logic              waiting;
  logic              stopped;

  modport master (
    output op, instr_off, flag_we, alu_zero, alu_neg, btn,
    input  rel_branch, offset, halt, in_strobe, waiting, stopped
  );

  modport slave (
    input  op, instr_off, flag_we, alu_zero, alu_neg, btn,
    output rel_branch, offset, halt, in_strobe, waiting, stopped
  );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch decode, flags and WAITB/HLT sequencing for the PC
// Optional button debouncer enabled by defining BRANCH_DEBOUNCE_EN.
module branch_ctrl #(
  parameter int AddrSz    = 6,
  parameter int DebCycles = 4
) (
  input logic         clk,
  input logic         n_reset,
  branch_ctrl_if.slave bus
);
  localparam logic [2:0] OP_BEQ   = 3'd1;
  localparam logic [2:0] OP_BNE   = 3'd2;
  localparam logic [2:0] OP_BLT   = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_WAITB = 3'd5;
  localparam logic [2:0] OP_HLT   = 3'd6;

  typedef enum logic [1:0] {RUN, W_PRESS, W_REL, STOP} state_t;

  if (DebCycles < 1) begin : g_bad_deb
    $error("DebCycles must be at least 1");
  end

  state_t            state, state_nxt;
  logic              z, n;
  logic              btn_meta, btn_sync, btn_s;
  logic [AddrSz-1:0] off;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= bus.btn;
      btn_sync <= btn_meta;
    end
  end

`ifdef BRANCH_DEBOUNCE_EN
  localparam int CntW = $clog2(DebCycles + 1);
  logic            deb_level;
  logic [CntW-1:0] deb_cnt;

  // Level flips only once the synchronised input has disagreed with it for
  // DebCycles cycles in a row; any agreement restarts the count.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (btn_sync != deb_level) begin
      if (deb_cnt == CntW'(DebCycles - 1)) begin
        deb_level <= btn_sync;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign btn_s = deb_level;
`else
  assign btn_s = btn_sync;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= RUN;
      z     <= 1'b0;
      n     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && bus.flag_we && bus.op != OP_WAITB && bus.op != OP_HLT) begin
        z <= bus.alu_zero;
        n <= bus.alu_neg;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.rel_branch = 1'b0;
    bus.halt       = 1'b0;
    bus.in_strobe  = 1'b0;
    case (state)
      RUN: begin
        case (bus.op)
          OP_BEQ:   bus.rel_branch = z;
          OP_BNE:   bus.rel_branch = !z;
          OP_BLT:   bus.rel_branch = n;
          OP_JMP:   bus.rel_branch = 1'b1;
          OP_WAITB: begin
            bus.halt  = 1'b1;
            state_nxt = W_PRESS;
          end
          OP_HLT: begin
            bus.halt  = 1'b1;
            state_nxt = STOP;
          end
          default: ;
        endcase
      end
      W_PRESS: begin
        bus.halt = 1'b1;
        if (btn_s) begin
          bus.in_strobe = 1'b1;
          state_nxt     = W_REL;
        end
      end
      // Dropping halt for the release cycle lets the PC step past WAITB.
      W_REL: begin
        if (btn_s) bus.halt = 1'b1;
        else       state_nxt = RUN;
      end
      STOP: bus.halt = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  assign off         = bus.instr_off;
  assign bus.offset  = off;
  assign bus.waiting = (state == W_PRESS) || (state == W_REL);
  assign bus.stopped = (state == STOP);
endmodule
